// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweep_pkg
// Description : Shared types and constants for the sweep counter controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_t;

    localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/updown_counter_core.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_core
// Description : Up/down counter with synchronous load and count enable.
//               Wraps naturally at both ends of its range.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_core
    import sweep_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Load wins over a count step; otherwise step in the requested direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sweep_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sweep_counter_ctrl
// Description : Sequences an up/down counter through triangular sweeps
//               between latched lower/upper limits, paced by a prescaler.
//               Supports single-sweep and continuous ping-pong modes.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_counter_ctrl
    import sweep_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int WIDTH    = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             dir_up,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int              c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_UP   = UP;
    localparam logic [1:0] c_ST_DOWN = DOWN;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_mode;
    logic             r_dir_up;
    logic             r_done;
    logic             r_err;
    logic [c_PW-1:0]  r_presc;

    logic             w_idle;
    logic             w_busy;
    logic             w_tick;
    logic             w_step;
    logic             w_accept;
    logic             w_reject;
    logic             w_at_hi;
    logic             w_at_lo;
    logic             w_en;
    logic             w_up;
    logic [WIDTH-1:0] w_count;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_busy   = !w_idle;
    assign w_tick   = w_busy && (r_presc == c_PRE_LAST);
    // A stop in the same cycle as a tick suppresses the step.
    assign w_step   = w_tick && !stop;
    assign w_accept = w_idle && start && !stop && (lo <= hi);
    assign w_reject = w_idle && start && !stop && (lo > hi);
    assign w_at_hi  = (w_count == r_hi);
    assign w_at_lo  = (w_count == r_lo);

    // Counter step request: move only when not sitting on the turning limit.
    always_comb begin
        w_en = 1'b0;
        w_up = 1'b1;
        if (w_step) begin
            if ((r_state == c_ST_UP) && !w_at_hi) begin
                w_en = 1'b1;
                w_up = 1'b1;
            end else if ((r_state == c_ST_DOWN) && !w_at_lo) begin
                w_en = 1'b1;
                w_up = 1'b0;
            end
        end
    end

    // Prescaler: free-runs 0..PRESCALE-1 while busy, held at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (!w_busy || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // Sweep FSM with latched limits, direction and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_mode   <= 1'b0;
            r_dir_up <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_lo     <= lo;
                        r_hi     <= hi;
                        r_mode   <= mode;
                        r_dir_up <= 1'b1;
                        r_state  <= c_ST_UP;
                    end
                end
                c_ST_UP: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_tick && w_at_hi) begin
                        // Dwell one step at the peak while turning round.
                        r_dir_up <= 1'b0;
                        r_state  <= c_ST_DOWN;
                    end
                end
                c_ST_DOWN: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_tick && w_at_lo) begin
                        if (r_mode) begin
                            r_dir_up <= 1'b1;
                            r_state  <= c_ST_UP;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    updown_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (w_en),
        .load     (w_accept),
        .load_val (lo),
        .up       (w_up),
        .count    (w_count)
    );

    assign count  = w_count;
    assign dir_up = r_dir_up;
    assign busy   = w_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sweep_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_counter_ctrl
// Description : Self-checking bench for sweep_counter_ctrl. Two instances
//               (PRESCALE 1 and 4) share stimulus; expected behaviour comes
//               from a closed-form sweep model (phase within the triangle).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sweep_counter_ctrl;

    localparam int PRE0 = 1;
    localparam int PRE1 = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] lo;
    logic [3:0] hi;

    logic [3:0] cnt  [2];
    logic       dir  [2];
    logic       bsy  [2];
    logic       dne  [2];
    logic       erp  [2];

    int total = 0;
    int bad   = 0;
    int exp_idle [2];

    always #5 clk = ~clk;

    sweep_counter_ctrl #(.PRESCALE(PRE0)) u_p1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lo(lo), .hi(hi),
        .mode(mode), .count(cnt[0]), .dir_up(dir[0]), .busy(bsy[0]),
        .done(dne[0]), .err(erp[0])
    );

    sweep_counter_ctrl #(.PRESCALE(PRE1)) u_p4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lo(lo), .hi(hi),
        .mode(mode), .count(cnt[1]), .dir_up(dir[1]), .busy(bsy[1]),
        .done(dne[1]), .err(erp[1])
    );

    // Closed-form expectation for cycle c after the accepting edge.
    task automatic model(input int k, input int c, input int l, input int h,
                         input int m, input int stop_at,
                         output int e_cnt, output int e_busy,
                         output int e_done, output int e_dir);
        int  p, d, per, ce, t, ph;
        bit  stopped, fin;
        p       = (k == 0) ? PRE0 : PRE1;
        d       = h - l;
        per     = 2 * (d + 1);
        stopped = (stop_at >= 0) && (c > stop_at);
        ce      = stopped ? stop_at : c;
        t       = ce / p;
        fin     = (m == 0) && (t >= per);
        ph      = fin ? 0 : (t % per);
        e_cnt   = (ph <= d) ? (l + ph) : (h - (ph - d - 1));
        e_dir   = (ph <= d) ? 1 : 0;
        e_busy  = (!stopped && !fin) ? 1 : 0;
        e_done  = (!stopped && fin && (ce == per * p)) ? 1 : 0;
    endtask

    // Start a sweep and check every cycle; optional stop / reset cycle.
    task automatic run_sweep(input int l, input int h, input int m,
                             input int stop_at, input int rst_at);
        int per, cend, ec, eb, ed, edir;
        per  = 2 * (h - l + 1);
        cend = per * PRE1;
        if (stop_at >= 0 && stop_at < cend) cend = stop_at + 1;
        if (rst_at >= 0 && rst_at < cend) cend = rst_at;
        lo    = 4'(l);
        hi    = 4'(h);
        mode  = 1'(m);
        start = 1'b1;
        stop  = 1'b0;
        for (int c = 0; c <= cend; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                model(k, c, l, h, m, stop_at, ec, eb, ed, edir);
                total++;
                if (cnt[k] !== 4'(ec)) begin
                    bad++;
                    $display("FAIL count dut%0d lo=%0d hi=%0d m=%0d c=%0d got=%0d exp=%0d",
                             k, l, h, m, c, cnt[k], ec);
                end
                total++;
                if (bsy[k] !== 1'(eb)) begin
                    bad++;
                    $display("FAIL busy dut%0d c=%0d got=%0b exp=%0b", k, c, bsy[k], eb);
                end
                total++;
                if (dne[k] !== 1'(ed)) begin
                    bad++;
                    $display("FAIL done dut%0d c=%0d got=%0b exp=%0b", k, c, dne[k], ed);
                end
                total++;
                if (erp[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL err_busy dut%0d c=%0d got=%0b exp=0", k, c, erp[k]);
                end
                if (eb != 0) begin
                    total++;
                    if (dir[k] !== 1'(edir)) begin
                        bad++;
                        $display("FAIL dir_up dut%0d c=%0d got=%0b exp=%0b", k, c, dir[k], edir);
                    end
                end
                if (c == cend) exp_idle[k] = ec;
            end
            // A second start one cycle into the sweep must be ignored.
            start = (c == 0);
            if (c == 0) begin
                lo   = 4'($urandom);
                hi   = 4'($urandom);
                mode = 1'($urandom);
            end
            stop = (c == stop_at);
            if (c == rst_at) begin
                reset = 1'b1;
                start = 1'b1;
                lo    = 4'(l);
                hi    = 4'(h);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        if (rst_at >= 0) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (cnt[k] !== 4'd0 || dir[k] !== 1'b1 || bsy[k] !== 1'b0 ||
                    dne[k] !== 1'b0 || erp[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid dut%0d got cnt=%0d dir=%0b busy=%0b done=%0b err=%0b exp 0/1/0/0/0",
                             k, cnt[k], dir[k], bsy[k], dne[k], erp[k]);
                end
                exp_idle[k] = 0;
            end
            reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        lo    = 4'd1;
        hi    = 4'd5;
        mode  = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (cnt[k] !== 4'd0 || dir[k] !== 1'b1 || bsy[k] !== 1'b0 ||
                dne[k] !== 1'b0 || erp[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d got cnt=%0d dir=%0b busy=%0b done=%0b err=%0b exp 0/1/0/0/0",
                         k, cnt[k], dir[k], bsy[k], dne[k], erp[k]);
            end
            exp_idle[k] = 0;
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (bsy[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_release dut%0d busy got=%0b exp=0", k, bsy[k]);
            end
        end
    endtask

    task automatic test_err(input int l, input int h);
        lo    = 4'(l);
        hi    = 4'(h);
        mode  = 1'b0;
        start = 1'b1;
        stop  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (erp[k] !== 1'b1 || bsy[k] !== 1'b0 || cnt[k] !== 4'(exp_idle[k])) begin
                bad++;
                $display("FAIL err_pulse dut%0d lo=%0d hi=%0d got err=%0b busy=%0b cnt=%0d exp 1/0/%0d",
                         k, l, h, erp[k], bsy[k], cnt[k], exp_idle[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (erp[k] !== 1'b0 || bsy[k] !== 1'b0 || cnt[k] !== 4'(exp_idle[k])) begin
                bad++;
                $display("FAIL err_clear dut%0d got err=%0b busy=%0b cnt=%0d exp 0/0/%0d",
                         k, erp[k], bsy[k], cnt[k], exp_idle[k]);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        lo    = 4'd3;
        hi    = 4'd8;
        mode  = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (bsy[k] !== 1'b0 || erp[k] !== 1'b0 || cnt[k] !== 4'(exp_idle[k])) begin
                    bad++;
                    $display("FAIL start_stop dut%0d got busy=%0b err=%0b cnt=%0d exp 0/0/%0d",
                             k, bsy[k], erp[k], cnt[k], exp_idle[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        run_sweep(2, 5, 0, -1, -1);
        run_sweep(0, 1, 0, -1, -1);
    endtask

    task automatic test_pingpong_stop();
        run_sweep(14, 15, 1, 2, -1);
        run_sweep(14, 15, 1, 13, -1);
    endtask

    task automatic test_equal_limits();
        run_sweep(9, 9, 0, -1, -1);
    endtask

    task automatic test_reset_mid();
        run_sweep(2, 6, 0, -1, 7);
    endtask

    task automatic test_back_to_back();
        run_sweep(3, 4, 0, -1, -1);
        run_sweep(3, 4, 0, -1, -1);
        run_sweep(1, 3, 0, -1, -1);
    endtask

    task automatic test_random();
        int l, h, m, per, sa;
        for (int i = 0; i < 25; i++) begin
            l = int'($urandom_range(0, 15));
            h = int'($urandom_range(0, 15));
            if (l > h) begin
                test_err(l, h);
            end else begin
                m   = int'($urandom_range(0, 1));
                per = 2 * (h - l + 1);
                if (m == 1)
                    sa = int'($urandom_range(0, per * PRE1 - 1));
                else if ($urandom_range(0, 1) == 1)
                    sa = int'($urandom_range(0, per * PRE1));
                else
                    sa = -1;
                run_sweep(l, h, m, sa, -1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        lo    = 4'd0;
        hi    = 4'd0;
        test_reset();
        test_basic();
        test_err(7, 3);
        test_pingpong_stop();
        test_equal_limits();
        test_reset_mid();
        test_start_stop_idle();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
